controle_bcd_seq: RTL and testbench
===================================

// Module: controle_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter/controller feeding the four 7-segment digit decoders.
//   Converts a 14-bit result to units/tens/hundreds/thousands with iterative double-dabble.
//   One add-3/shift step per clock; start/busy/done handshake.
//   Holds the last converted digits and flag stable for the display path between conversions.
// PARAMETERS
//   IN_W     14    binary input width; one iteration per bit.
//   DIGITS   4     number of BCD digits produced. Fixed at 4 for this display.
//   MAX_VAL  9999  largest displayable value; above this the output saturates.
// PORTS
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous reset, active-high
//   start     in   1   conversion request; sampled only in IDLE
//   flag_in   in   1   decoder enable/flag, captured together with result
//   result    in   14  unsigned binary value to convert
//   busy      out  1   high while a conversion is in progress
//   done      out  1   one-cycle pulse; digits/flag_out/err_over updated this cycle
//   valid     out  1   high once any conversion has completed since reset
//   err_over  out  1   last captured result > MAX_VAL
//   flag_out  out  1   flag_in captured with the displayed value
//   bcd_uni   out  4   units digit, 0..9
//   bcd_dez   out  4   tens digit, 0..9
//   bcd_cen   out  4   hundreds digit, 0..9
//   bcd_mil   out  4   thousands digit, 0..9
// BEHAVIOUR
//   Reset (async, rst=1):
//     - state=IDLE.
//     - busy=done=valid=err_over=flag_out=0.
//     - All bcd_* = 0; shift register and counter cleared.
//     - Reset mid-conversion aborts it; no done pulse is produced.
//   FSM, two states: IDLE, CONV.
//   IDLE:
//     - On edge with start=1: capture result into the 14-bit shift register and flag_in into the flag latch.
//     - Same edge: ovf = (result > MAX_VAL), 16-bit BCD accumulator = 0, count = 0, busy=1, go to CONV.
//   CONV, each edge:
//     - For each 4-bit accumulator digit that is >= 5, add 3 (all digits in parallel, same cycle).
//     - Then shift {acc, sreg} left by 1 as one 30-bit word; count++.
//     - The edge with count == IN_W-1 performs the final step and returns to IDLE.
//   Completion edge (the 14th CONV edge):
//     - Load bcd_* from the final accumulator. If ovf, load 9,9,9,9 instead.
//     - err_over=ovf, flag_out=captured flag, valid=1, done=1, busy=0.
//   Latency: done is high in the cycle after the 14th edge following the accepting edge,
//     i.e. exactly IN_W cycles after start is sampled.
//   done: high for exactly one cycle, then cleared on the next edge.
//   Start handling:
//     - start while busy is ignored; no queueing.
//     - start held high in the done cycle (state=IDLE) is accepted: back-to-back conversions, one idle gap.
//   Result stability: result and flag_in may change freely after the accepting edge; the captured copy is used.
//   Output hold: bcd_*/flag_out/err_over change only on completion edges or reset.
//   Width rule: the 16-bit accumulator never overflows when ovf=0; when ovf=1, its contents are discarded.
// TESTING
//   1. result=1234, start 1 cycle -> busy 14 cycles; done after 14 cycles; digits 1,2,3,4; err_over=0; valid=1.
//   2. result=0, then result=9999 -> digits 0,0,0,0, then 9,9,9,9; err_over=0 both times.
//   3. result=10000, then result=16383 -> digits 9,9,9,9 and err_over=1 both times; done timing unchanged.
//   4. result=0042, flag_in=1; pulse start; during busy change result=7777 and pulse start ->
//      outputs 0,0,4,2 with flag_out=1; the second start is ignored; only one done pulse.
//   5. start held high continuously with result=500 -> done pulses every 15 cycles; digits stay 0,5,0,0.
//   6. rst asserted at CONV cycle 7 after a prior completed 321 ->
//      immediate busy=0, valid=0, digits 0; no done pulse; next start converts normally.

Source files
------------

// File: rtl/controle_bcd_seq_if.sv
// Handshake and display bus between the result source and the BCD converter.
// The master drives start/result/flag_in; the slave returns status and digits.
interface controle_bcd_seq_if #(
  parameter int IN_W = 14
);
  logic            start;
  logic            flag_in;
  logic [IN_W-1:0] result;
  logic            busy;
  logic            done;
  logic            valid;
  logic            err_over;
  logic            flag_out;
  logic [3:0]      bcd_uni;
  logic [3:0]      bcd_dez;
  logic [3:0]      bcd_cen;
  logic [3:0]      bcd_mil;

  modport master (
    output start, flag_in, result,
    input  busy, done, valid, err_over, flag_out,
    input  bcd_uni, bcd_dez, bcd_cen, bcd_mil
  );

  modport slave (
    input  start, flag_in, result,
    output busy, done, valid, err_over, flag_out,
    output bcd_uni, bcd_dez, bcd_cen, bcd_mil
  );
endinterface

// File: rtl/controle_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one add-3/shift per clock,
// IN_W cycles from accepted start to done; start is ignored while busy.
module controle_bcd_seq #(
  parameter int IN_W    = 14,
  parameter int DIGITS  = 4,
  parameter int MAX_VAL = 9999
) (
  input  logic                clk,
  input  logic                rst,
  controle_bcd_seq_if.slave   ctl
);

  localparam int                ACC_W = 4 * DIGITS;
  localparam int                CNT_W = $clog2(IN_W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(IN_W - 1);
  localparam logic [IN_W-1:0]   MAX_V = IN_W'(MAX_VAL);
  localparam logic [ACC_W-1:0]  SAT   = {DIGITS{4'd9}};

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state_q;
  logic [IN_W-1:0]   sreg_q, sreg_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_adj;
  logic [ACC_W+IN_W-1:0] word;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q, flag_q;
  logic              busy_q, done_q, valid_q, err_q, flag_out_q;
  logic [ACC_W-1:0]  bcd_q;

  // Add-3 correction on every digit in parallel, then one combined shift.
  always_comb begin
    acc_adj = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
    end
    word   = {acc_adj, sreg_q} << 1;
    acc_d  = word[ACC_W+IN_W-1 -: ACC_W];
    sreg_d = word[IN_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      flag_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      flag_out_q <= 1'b0;
      bcd_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ctl.start) begin
            sreg_q  <= ctl.result;
            flag_q  <= ctl.flag_in;
            ovf_q   <= (ctl.result > MAX_V);
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          acc_q  <= acc_d;
          sreg_q <= sreg_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // Saturated values discard the (possibly wrapped) accumulator.
            bcd_q      <= ovf_q ? SAT : acc_d;
            err_q      <= ovf_q;
            flag_out_q <= flag_q;
            valid_q    <= 1'b1;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctl.busy     = busy_q;
  assign ctl.done     = done_q;
  assign ctl.valid    = valid_q;
  assign ctl.err_over = err_q;
  assign ctl.flag_out = flag_out_q;
  assign ctl.bcd_uni  = bcd_q[3:0];
  assign ctl.bcd_dez  = bcd_q[7:4];
  assign ctl.bcd_cen  = bcd_q[11:8];
  assign ctl.bcd_mil  = bcd_q[15:12];

endmodule

// File: tb/tb_controle_bcd_seq.sv
// Randomized self-checking bench for controle_bcd_seq against a decimal-arithmetic model.
module tb_controle_bcd_seq;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  controle_bcd_seq_if #(.IN_W(14)) bus_if ();

  controle_bcd_seq #(.IN_W(14), .DIGITS(4), .MAX_VAL(9999)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] got_bcd();
    return {bus_if.bcd_mil, bus_if.bcd_cen, bus_if.bcd_dez, bus_if.bcd_uni};
  endfunction

  // Pulse start for one edge, scramble inputs afterwards, return latency and busy cycles.
  task automatic run_conv(input logic [13:0] v, input logic f, output int lat, output int bcnt);
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.result = v; bus_if.flag_in = f;
    @(negedge clk);
    bus_if.start = 1'b0; bus_if.result = 14'($urandom); bus_if.flag_in = 1'($urandom);
    lat = 0;
    bcnt = bus_if.busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus_if.done) begin lat = k; break; end
      if (bus_if.busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start = 1'b0; bus_if.result = '0; bus_if.flag_in = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus_if.busy, bus_if.done, bus_if.valid, bus_if.err_over, bus_if.flag_out} !== 5'b0 ||
        got_bcd() !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: flags=%b bcd=%h, required flags=00000 bcd=0000",
               {bus_if.busy, bus_if.done, bus_if.valid, bus_if.err_over, bus_if.flag_out}, got_bcd());
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bcnt;
    run_conv(14'd1234, 1'b0, lat, bcnt);
    tests++;
    if (lat !== 14 || bcnt !== 14) begin
      fails++; $display("FAIL basic_timing: latency=%0d busy=%0d, required 14/14", lat, bcnt);
    end
    tests++;
    if (got_bcd() !== ref_bcd(1234) || bus_if.err_over !== 1'b0 || bus_if.valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_value: bcd=%h err=%b valid=%b, required %h/0/1",
               got_bcd(), bus_if.err_over, bus_if.valid, ref_bcd(1234));
    end
    @(negedge clk);
    tests++;
    if (bus_if.done !== 1'b0 || got_bcd() !== ref_bcd(1234)) begin
      fails++; $display("FAIL done_pulse: done=%b bcd=%h, required 0/%h", bus_if.done, got_bcd(), ref_bcd(1234));
    end
  endtask

  task automatic test_values();
    int vals[12];
    int lat, bcnt;
    logic f;
    vals[0] = 0; vals[1] = 9999; vals[2] = 10000; vals[3] = 16383;
    for (int i = 4; i < 12; i++) vals[i] = (i % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
    foreach (vals[i]) begin
      f = 1'($urandom);
      run_conv(14'(vals[i]), f, lat, bcnt);
      tests++;
      if (lat !== 14 || got_bcd() !== ref_bcd(vals[i]) || bus_if.err_over !== (vals[i] > 9999) ||
          bus_if.flag_out !== f) begin
        fails++;
        $display("FAIL value_%0d: lat=%0d bcd=%h err=%b flag=%b, required 14 %h %b %b",
                 vals[i], lat, got_bcd(), bus_if.err_over, bus_if.flag_out,
                 ref_bcd(vals[i]), (vals[i] > 9999), f);
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.result = 14'd42; bus_if.flag_in = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) begin bus_if.result = 14'd7777; bus_if.flag_in = 1'b0; bus_if.start = 1'b1; end
      if (k == 6) bus_if.start = 1'b0;
      if (bus_if.done) ndone++;
    end
    tests++;
    if (ndone !== 1 || got_bcd() !== ref_bcd(42) || bus_if.flag_out !== 1'b1) begin
      fails++;
      $display("FAIL ignore_start: dones=%0d bcd=%h flag=%b, required 1 %h 1", ndone, got_bcd(), bus_if.flag_out, ref_bcd(42));
    end
  endtask

  task automatic test_back_to_back();
    int t[$];
    int bad = 0;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.result = 14'd500; bus_if.flag_in = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (bus_if.done) begin
        t.push_back(k);
        if (got_bcd() !== ref_bcd(500)) bad++;
      end
    end
    bus_if.start = 1'b0;
    tests++;
    if (t.size() < 4 || bad != 0) begin
      fails++; $display("FAIL b2b_count: dones=%0d bad_values=%0d, required >=4 and 0", t.size(), bad);
    end else begin
      for (int i = 1; i < t.size(); i++) begin
        tests++;
        if (t[i] - t[i-1] !== 15) begin
          fails++; $display("FAIL b2b_period: gap=%0d, required 15", t[i] - t[i-1]);
        end
      end
    end
    for (int k = 0; k < 40 && bus_if.busy; k++) @(negedge clk);
    tests++;
    if (bus_if.busy !== 1'b0) begin
      fails++; $display("FAIL b2b_drain: busy=%b, required 0", bus_if.busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, ndone = 0;
    run_conv(14'd321, 1'b1, lat, bcnt);
    tests++;
    if (got_bcd() !== ref_bcd(321) || bus_if.valid !== 1'b1) begin
      fails++; $display("FAIL pre_reset: bcd=%h valid=%b, required %h 1", got_bcd(), bus_if.valid, ref_bcd(321));
    end
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.result = 14'd8765; bus_if.flag_in = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (bus_if.busy !== 1'b0 || bus_if.valid !== 1'b0 || bus_if.done !== 1'b0 ||
        bus_if.flag_out !== 1'b0 || got_bcd() !== 16'h0) begin
      fails++;
      $display("FAIL mid_reset: busy=%b valid=%b done=%b flag=%b bcd=%h, required 0 0 0 0 0000",
               bus_if.busy, bus_if.valid, bus_if.done, bus_if.flag_out, got_bcd());
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_if.done || bus_if.busy) ndone++;
    end
    tests++;
    if (ndone !== 0) begin
      fails++; $display("FAIL abort_no_done: activity=%0d, required 0", ndone);
    end
    run_conv(14'd4321, 1'b0, lat, bcnt);
    tests++;
    if (lat !== 14 || got_bcd() !== ref_bcd(4321) || bus_if.valid !== 1'b1) begin
      fails++;
      $display("FAIL post_reset: lat=%0d bcd=%h valid=%b, required 14 %h 1", lat, got_bcd(), bus_if.valid, ref_bcd(4321));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
